// File: rtl/pcmcia_attr_ctrl.sv
// pcmcia_attr_ctrl: attribute-space front end with strobe sync, COR and stretched soft reset.
// Define PCMCIA_ATTR_TIMEOUT_EN to build the stuck-cycle abort (TIMEOUT).
module pcmcia_attr_ctrl #(
    parameter int         SYNC_STAGES    = 2,
    parameter logic [8:0] COR_ADDR       = 9'h100,
    parameter int         SRESET_CYCLES  = 16,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       _CE1,
    input  logic       _CE2,
    input  logic       _REG,
    input  logic       _OE,
    input  logic       _WE,
    input  logic [8:0] A,
    inout  wire  [7:0] D,
    output logic [7:0] COR,
    output logic       CFG_EN,
    output logic       SRESET,
    output logic       CYC_RD,
    output logic       CYC_WR,
    output logic       CYC_ATTR,
    output logic       TIMEOUT
);
    localparam int SW = $clog2(SRESET_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t     state_q;
    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] s;
    logic       sel, rd_end, wr_end, start, commit, to_hit, start_ok;
    logic [8:0] cap_a_q;
    logic [7:0] cap_d_q, cor_q, cor_d;
    logic       cap_reg_q, cap_ce1_q, cap_v_q;
    logic [SW-1:0] cnt_q, cnt_d;
    logic       cfg_q, cyc_rd_q, cyc_wr_q, cyc_attr_q;

    // s = synchronised {_WE, _OE, _REG, _CE2, _CE1}
    assign s      = sync_q[SYNC_STAGES-1];
    assign sel    = !s[0] | !s[1];
    assign rd_end = (state_q == RD) & (s[3] | !sel);
    assign wr_end = (state_q == WR) & (s[4] | !sel);
    assign start  = (state_q == IDLE) & start_ok & sel & (s[3] ^ s[4]);
    assign commit = wr_end & cap_v_q & !cap_reg_q & !cap_ce1_q & (cap_a_q == COR_ADDR);
    assign SRESET = cor_q[7] | (cnt_q != '0);

    // A 1->0 change of COR[7] reloads the stretch counter; setting COR[7] cancels it.
    assign cnt_d = (commit & cap_d_q[7]) ? '0 :
                   (commit & cor_q[7])   ? SW'(SRESET_CYCLES) :
                   (cnt_q != '0)         ? cnt_q - 1'b1 : '0;
    assign cor_d = commit ? {cap_d_q[7:6], (SRESET | cap_d_q[7]) ? 6'd0 : cap_d_q[5:0]} : cor_q;

    // Read-back is combinational on the raw strobes to meet access time.
    assign D = (!RESET & !_REG & !_CE1 & !_OE & (A == COR_ADDR)) ? cor_q : 'z;

    assign COR      = cor_q;
    assign CFG_EN   = cfg_q;
    assign CYC_RD   = cyc_rd_q;
    assign CYC_WR   = cyc_wr_q;
    assign CYC_ATTR = cyc_attr_q;

`ifdef PCMCIA_ATTR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;
    logic          to_q, wait_q;

    assign to_hit   = (state_q == RD | state_q == WR) & (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) & !rd_end & !wr_end;
    assign start_ok = !wait_q;
    assign TIMEOUT  = to_q;

    // After an abort, hold off new cycles until both strobes are seen released.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt_q <= '0;
            to_q     <= 1'b0;
            wait_q   <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == RD | state_q == WR) ? to_cnt_q + 1'b1 : '0;
            to_q     <= to_q | to_hit;
            wait_q   <= to_hit | (wait_q & !(s[3] & s[4]));
        end
    end
`else
    assign to_hit   = 1'b0;
    assign start_ok = 1'b1;
    assign TIMEOUT  = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
            state_q    <= IDLE;
            cap_a_q    <= '0;
            cap_d_q    <= '0;
            cap_reg_q  <= 1'b1;
            cap_ce1_q  <= 1'b1;
            cap_v_q    <= 1'b0;
            cor_q      <= '0;
            cnt_q      <= '0;
            cfg_q      <= 1'b0;
            cyc_rd_q   <= 1'b0;
            cyc_wr_q   <= 1'b0;
            cyc_attr_q <= 1'b0;
        end else begin
            sync_q[0] <= {_WE, _OE, _REG, _CE2, _CE1};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            state_q <= (rd_end | wr_end) ? DONE :
                       (to_hit | state_q == DONE) ? IDLE :
                       start ? (s[3] ? WR : RD) : state_q;
            if (state_q == WR & !_WE) begin
                cap_a_q   <= A;
                cap_d_q   <= D;
                cap_reg_q <= _REG;
                cap_ce1_q <= _CE1;
            end
            cap_v_q  <= (state_q == WR) & (cap_v_q | !_WE);
            cor_q    <= cor_d;
            cnt_q    <= cnt_d;
            cfg_q    <= |cor_q[5:0];
            cyc_rd_q <= rd_end;
            cyc_wr_q <= wr_end;
            if (rd_end | wr_end) cyc_attr_q <= rd_end ? s[2] : cap_reg_q;
        end
    end
endmodule

// File: tb/tb_pcmcia_attr_ctrl.sv
// tb_pcmcia_attr_ctrl: vector table, hand sequences and random bus cycles against a transaction model.
module tb_pcmcia_attr_ctrl;
    logic clk = 0, rst = 1, ce1_n = 1, ce2_n = 1, reg_n = 1, oe_n = 1, we_n = 1;
    logic [8:0] a = '0;
    logic [7:0] dq = '0;
    logic den = 0;
    wire  [7:0] d;
    logic [7:0] cor;
    logic cfg_en, sreset, cyc_rd, cyc_wr, cyc_attr, timeout;

    assign d = den ? dq : 'z;
    always #5 clk = ~clk;

    pcmcia_attr_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .CLK(clk), .RESET(rst), ._CE1(ce1_n), ._CE2(ce2_n), ._REG(reg_n), ._OE(oe_n), ._WE(we_n),
        .A(a), .D(d), .COR(cor), .CFG_EN(cfg_en), .SRESET(sreset), .CYC_RD(cyc_rd), .CYC_WR(cyc_wr),
        .CYC_ATTR(cyc_attr), .TIMEOUT(timeout)
    );

    int total = 0, bad = 0;
    int cyc = 0, n_rd = 0, n_wr = 0, wr_cyc = 0, fall_cyc = -1;
    logic attr_seen = 0, cfg_at_wr = 0, sr_prev = 0;
    logic [7:0] cor_at_wr = '0;
    logic [7:0] m_cor = '0;

    always @(negedge clk) begin
        cyc++;
        if (cyc_rd) n_rd++;
        if (cyc_wr) begin
            n_wr++;
            cor_at_wr = cor;
            cfg_at_wr = cfg_en;
            wr_cyc = cyc;
        end
        if (cyc_rd | cyc_wr) attr_seen = cyc_attr;
        if (sr_prev & !sreset) fall_cyc = cyc;
        sr_prev = sreset;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected COR after a cycle, assuming no stretch count is running.
    function automatic logic [7:0] cor_after(input logic [7:0] cur, input bit wr, input bit rg, input bit c1,
                                             input logic [8:0] ad, input logic [7:0] dv);
        if (!wr || rg || c1 || ad != 9'h100) return cur;
        return {dv[7:6], (cur[7] | dv[7]) ? 6'd0 : dv[5:0]};
    endfunction

    task automatic bus(input bit wr, input bit rg, input bit c1, input bit c2, input logic [8:0] ad,
                       input logic [7:0] dv, input int n, input bit probe, output logic [7:0] rv);
        @(negedge clk);
        a = ad; reg_n = rg; ce1_n = c1; ce2_n = c2;
        dq = wr ? dv : 8'h00;
        den = wr | probe;
        @(negedge clk);
        if (wr) we_n = 0; else oe_n = 0;
        repeat (n) @(negedge clk);
        rv = d;
        we_n = 1; oe_n = 1;
        @(negedge clk);
        den = 0; ce1_n = 1; ce2_n = 1; reg_n = 1;
        repeat (8) @(negedge clk);
    endtask

    task automatic xact(input bit wr, input bit rg, input bit c1, input bit c2, input logic [8:0] ad,
                        input logic [7:0] dv, input int n, input logic [7:0] ec, input bit drv, input bit esr);
        int br, bw;
        logic [7:0] rv;
        br = n_rd; bw = n_wr;
        bus(wr, rg, c1, c2, ad, dv, n, !drv, rv);
        chk("cyc_wr_count", n_wr - bw, wr ? 1 : 0);
        chk("cyc_rd_count", n_rd - br, wr ? 0 : 1);
        chk("cyc_attr", attr_seen, rg);
        if (wr) begin
            chk("cor_at_commit", cor_at_wr, ec);
            chk("cfg_en_lag", cfg_at_wr, |m_cor[5:0]);
        end else chk("read_data", rv, drv ? m_cor : 8'h00);
        chk("cor", cor, ec);
        chk("cfg_en", cfg_en, |ec[5:0]);
        chk("sreset", sreset, esr);
        m_cor = ec;
    endtask

    typedef struct {
        bit wr, rg, c1, c2;
        logic [8:0] a;
        logic [7:0] d, cor;
        bit drv;
    } vec_t;

    vec_t vt [11];

    initial begin
        int br, bw;
        vt[0]  = '{1, 0, 0, 1, 9'h100, 8'h01, 8'h01, 0};
        vt[1]  = '{1, 0, 0, 1, 9'h100, 8'h41, 8'h41, 0};
        vt[2]  = '{0, 0, 0, 1, 9'h100, 8'h00, 8'h41, 1};
        vt[3]  = '{1, 1, 0, 1, 9'h100, 8'hFF, 8'h41, 0};
        vt[4]  = '{1, 0, 1, 0, 9'h100, 8'h00, 8'h41, 0};
        vt[5]  = '{1, 0, 0, 1, 9'h0FF, 8'h00, 8'h41, 0};
        vt[6]  = '{0, 0, 0, 1, 9'h0FF, 8'h00, 8'h41, 0};
        vt[7]  = '{0, 1, 0, 1, 9'h100, 8'h00, 8'h41, 0};
        vt[8]  = '{0, 0, 1, 0, 9'h100, 8'h00, 8'h41, 0};
        vt[9]  = '{1, 0, 0, 0, 9'h100, 8'h3C, 8'h3C, 0};
        vt[10] = '{1, 0, 0, 1, 9'h100, 8'h00, 8'h00, 0};

        repeat (2) @(negedge clk);
        chk("rst_cor", cor, 8'h00);
        chk("rst_cfg_en", cfg_en, 0);
        chk("rst_sreset", sreset, 0);
        chk("rst_cyc_rd", cyc_rd, 0);
        chk("rst_cyc_wr", cyc_wr, 0);
        chk("rst_cyc_attr", cyc_attr, 0);
        chk("rst_timeout", timeout, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++)
            xact(vt[i].wr, vt[i].rg, vt[i].c1, vt[i].c2, vt[i].a, vt[i].d, 6, vt[i].cor, vt[i].drv,
                 vt[i].cor[7] | m_cor[7]);

        xact(1, 0, 0, 1, 9'h100, 8'h81, 6, 8'h80, 0, 1);
        xact(1, 0, 0, 1, 9'h100, 8'h01, 6, 8'h00, 0, 1);
        repeat (20) @(negedge clk);
        chk("sreset_stretch", fall_cyc - wr_cyc, 16);
        chk("sreset_after", sreset, 0);
        chk("cor_after_stretch", cor, 8'h00);
        xact(1, 0, 0, 1, 9'h100, 8'h01, 6, 8'h01, 0, 0);

        br = n_rd; bw = n_wr;
        @(negedge clk);
        a = 9'h100; reg_n = 0; ce1_n = 0;
        @(negedge clk);
        oe_n = 0; we_n = 0;
        repeat (6) @(negedge clk);
        oe_n = 1; we_n = 1;
        @(negedge clk);
        ce1_n = 1; reg_n = 1;
        repeat (8) @(negedge clk);
        chk("illegal_rd", n_rd - br, 0);
        chk("illegal_wr", n_wr - bw, 0);
        chk("illegal_cor", cor, m_cor);

        bw = n_wr;
        @(negedge clk);
        a = 9'h100; reg_n = 0; ce1_n = 0; dq = 8'h55; den = 1;
        @(negedge clk);
        we_n = 0;
        repeat (5) @(negedge clk);
        rst = 1;
        we_n = 1; ce1_n = 1; reg_n = 1; den = 0;
        @(negedge clk);
        rst = 0;
        repeat (8) @(negedge clk);
        chk("rst_mid_wr_pulse", n_wr - bw, 0);
        chk("rst_mid_wr_cor", cor, 8'h00);
        chk("rst_mid_wr_cfg", cfg_en, 0);
        m_cor = 8'h00;

        for (int k = 0; k < 30; k++) begin
            bit wr, rg, c1, c2, drv;
            logic [8:0] ad;
            logic [7:0] dv, nc;
            wr = 1'($urandom);
            rg = ($urandom_range(0, 3) == 0);
            c1 = 1'($urandom);
            c2 = c1 ? 1'b0 : 1'($urandom);
            ad = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h100;
            dv = 8'($urandom);
            nc = cor_after(m_cor, wr, rg, c1, ad, dv);
            drv = !wr & !rg & !c1 & (ad == 9'h100);
            xact(wr, rg, c1, c2, ad, dv, $urandom_range(4, 8), nc, drv, nc[7] | m_cor[7]);
            repeat (20) @(negedge clk);
        end

        br = n_rd;
        @(negedge clk);
        a = 9'h100; reg_n = 0; ce1_n = 0;
        @(negedge clk);
        oe_n = 0;
        repeat (10) @(negedge clk);
        chk("timeout_early", timeout, 0);
        @(negedge clk);
`ifdef PCMCIA_ATTR_TIMEOUT_EN
        chk("timeout_set", timeout, 1);
`else
        chk("timeout_tied", timeout, 0);
`endif
        repeat (9) @(negedge clk);
        oe_n = 1;
        @(negedge clk);
        ce1_n = 1; reg_n = 1;
        repeat (8) @(negedge clk);
`ifdef PCMCIA_ATTR_TIMEOUT_EN
        chk("timeout_no_rd", n_rd - br, 0);
        chk("timeout_sticky", timeout, 1);
`else
        chk("long_rd_pulse", n_rd - br, 1);
        chk("long_rd_timeout", timeout, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
